// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// IMEM_LOADER_CHECKSUM_EN adds the CHECK state for a trailing checksum byte.
package imem_loader_pkg;

    localparam int WORD_BYTES    = 4;
    localparam int DEFAULT_DEPTH = 128;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = stream source / memory side, slave = the loader itself.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_wr_en, mem_wr_addr, mem_wr_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_wr_en, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/imem_byte_packer.sv
// Big-endian byte-to-word packer: first byte lands in [31:24].
// word_valid flags the byte that completes a word (combinational).
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0] byte_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (clr) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (byte_vld) begin
            word     <= {word[23:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    assign word_valid = byte_vld && (byte_cnt == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory one word at a time while holding the CPU.
// Define IMEM_LOADER_CHECKSUM_EN to verify a trailing mod-256 checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_words,
    imem_loader_if.slave     bus,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] word_idx;
    logic [CNT_W-1:0] last_idx;
    logic [CNT_W-1:0] n_clamp;
    logic [31:0]      word;
    logic             word_valid;
    logic             start_acc;
    logic             byte_fire;
    logic             last_word;
    logic             in_ready_c;
    logic             wr_en_c;
    logic             busy_c;

    assign start_acc = start && (state == IDLE || state == DONE);
    assign byte_fire = bus.in_valid && in_ready_c;
    assign last_word = (CNT_W'(word_idx) == last_idx);
    assign n_clamp   = (32'(num_words) > 32'(DEPTH)) ? CNT_W'(DEPTH) : num_words;

    imem_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start_acc),
        .byte_vld   (byte_fire && state == RECV),
        .byte_in    (bus.in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        in_ready_c = 1'b0;
        wr_en_c    = 1'b0;
        busy_c     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start_acc) state_nxt = (num_words == '0) ? DONE : RECV;
            end
            RECV: begin
                busy_c     = 1'b1;
                in_ready_c = 1'b1;
                if (word_valid) state_nxt = WRITE;
            end
            WRITE: begin
                busy_c  = 1'b1;
                wr_en_c = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_nxt = last_word ? CHECK : RECV;
`else
                state_nxt = last_word ? DONE : RECV;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                busy_c     = 1'b1;
                in_ready_c = 1'b1;
                if (bus.in_valid) state_nxt = DONE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // last_idx is only consulted in WRITE, so a zero-length start leaving it
    // at all-ones is harmless; it also bounds word_idx to DEPTH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx <= '0;
            last_idx <= '0;
        end else if (start_acc) begin
            word_idx <= '0;
            last_idx <= n_clamp - CNT_W'(1);
        end else if (state == WRITE && !last_word) begin
            word_idx <= word_idx + IDX_W'(1);
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic       error_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum     <= '0;
            error_q <= 1'b0;
        end else if (start_acc) begin
            sum     <= '0;
            error_q <= 1'b0;
        end else if (byte_fire) begin
            sum <= sum + bus.in_data;
            if (state == CHECK) error_q <= ((sum + bus.in_data) != 8'd0);
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign bus.in_ready    = in_ready_c;
    assign bus.mem_wr_en   = wr_en_c;
    assign bus.mem_wr_addr = wr_en_c ? 32'({word_idx, 2'b00}) : '0;
    assign bus.mem_wr_data = wr_en_c ? word : '0;
    assign busy            = busy_c;
    assign cpu_hold        = busy_c;
    assign done            = (state == DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued at stimulus time,
// popped when mem_wr_en is seen. Checksum scenarios need IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int DEPTH = 128;
    localparam int CNT_W = 8;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_words = '0;
    logic             cpu_hold, busy, done, error;

    wr_t         exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          wr_cnt = 0;
    logic [31:0] last_addr = '0;
    logic [7:0]  csum = '0;

    imem_loader_if bus ();

    imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_words (num_words),
        .bus       (bus.slave),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // scoreboard pop: every write strobe must match the next queued write
    task automatic monitor();
        wr_t e;
        if (bus.mem_wr_en === 1'b1) begin
            n_cmp++;
            wr_cnt++;
            last_addr = bus.mem_wr_addr;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL wr_unexpected: got addr=%h data=%h, expected no write",
                         bus.mem_wr_addr, bus.mem_wr_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.mem_wr_addr !== e.addr || bus.mem_wr_data !== e.data) begin
                    n_err++;
                    $display("FAIL wr_match: got addr=%h data=%h, expected addr=%h data=%h",
                             bus.mem_wr_addr, bus.mem_wr_data, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            monitor();
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (acc) csum = csum + b;
        else begin
            n_cmp++;
            n_err++;
            $display("FAIL byte_timeout: byte %h not accepted, expected in_ready", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input bit gap);
        exp_q.push_back('{addr: addr, data: w});
        for (int k = 0; k < 4; k++) begin
            send_byte(w[31-8*k -: 8]);
            if (gap && k < 3) tick();
        end
        // write strobe must follow the 4th byte by exactly one cycle
        @(negedge clk);
        n_cmp++;
        if (bus.mem_wr_en !== 1'b1) begin
            n_err++;
            $display("FAIL wr_latency: mem_wr_en=%b one cycle after word %h, expected 1",
                     bus.mem_wr_en, w);
        end
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00 - csum);
`endif
    endtask

    task automatic do_start(input logic [CNT_W-1:0] n);
        start     = 1'b1;
        num_words = n;
        csum      = '0;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (done === 1'b1) ok = 1;
            else tick();
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL done_timeout: done=%b, expected 1", done);
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_cmp++;
        if ({bus.in_ready, bus.mem_wr_en, busy, cpu_hold, done, error} !== 6'b0) begin
            n_err++;
            $display("FAIL %s_ctl: rdy/wr/busy/hold/done/err=%b, expected 000000", tag,
                     {bus.in_ready, bus.mem_wr_en, busy, cpu_hold, done, error});
        end
        n_cmp++;
        if (bus.mem_wr_addr !== 32'h0 || bus.mem_wr_data !== 32'h0) begin
            n_err++;
            $display("FAIL %s_bus: addr=%h data=%h, expected 0/0", tag,
                     bus.mem_wr_addr, bus.mem_wr_data);
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check_all_zero("post_reset");
    endtask

    task automatic test_load();
        int base;
        base = wr_cnt;
        do_start(8'd2);
        n_cmp++;
        if (busy !== 1'b1 || cpu_hold !== 1'b1) begin
            n_err++;
            $display("FAIL load_busy: busy=%b cpu_hold=%b, expected 1/1", busy, cpu_hold);
        end
        send_word(32'h2008_0005, 32'h000, 0);
        send_word(32'h8C09_0000, 32'h004, 0);
        finish_load();
        wait_done();
        n_cmp++;
        if (cpu_hold !== 1'b0 || error !== 1'b0) begin
            n_err++;
            $display("FAIL load_end: cpu_hold=%b error=%b, expected 0/0", cpu_hold, error);
        end
        n_cmp++;
        if (wr_cnt - base != 2 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL load_count: writes=%0d pending=%0d, expected 2/0",
                     wr_cnt - base, exp_q.size());
        end
    endtask

    task automatic test_gaps();
        int base;
        base = wr_cnt;
        do_start(8'd1);
        send_word(32'hDEAD_BEEF, 32'h000, 1);
        finish_load();
        wait_done();
        n_cmp++;
        if (wr_cnt - base != 1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL gaps_count: writes=%0d pending=%0d, expected 1/0",
                     wr_cnt - base, exp_q.size());
        end
    endtask

    task automatic test_clamp();
        int base;
        base = wr_cnt;
        do_start(8'd200);
        for (int i = 0; i < DEPTH; i++) send_word($urandom, 32'(i * 4), 0);
        finish_load();
        wait_done();
        n_cmp++;
        if (wr_cnt - base != DEPTH || last_addr !== 32'h1FC) begin
            n_err++;
            $display("FAIL clamp: writes=%0d last_addr=%h, expected %0d/000001fc",
                     wr_cnt - base, last_addr, DEPTH);
        end
        // stream must stay stalled once the load has finished
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if (bus.in_ready !== 1'b0 || wr_cnt - base != DEPTH) begin
            n_err++;
            $display("FAIL clamp_stall: in_ready=%b writes=%0d, expected 0/%0d",
                     bus.in_ready, wr_cnt - base, DEPTH);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int base;
        base = wr_cnt;
        do_start(8'd4);
        send_word(32'h1111_2222, 32'h000, 0);
        send_word(32'h3333_4444, 32'h004, 0);
        send_byte(8'h55);
        send_byte(8'h66);
        rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if (bus.in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_idle: in_ready=%b busy=%b done=%b, expected 0/0/0",
                     bus.in_ready, busy, done);
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (wr_cnt - base != 2 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rst_mid_writes: writes=%0d pending=%0d, expected 2/0",
                     wr_cnt - base, exp_q.size());
        end
        // zero-length load goes straight to DONE without writing
        base = wr_cnt;
        do_start(8'd0);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || wr_cnt != base) begin
            n_err++;
            $display("FAIL zero_len: done=%b busy=%b writes=%0d, expected 1/0/0",
                     done, busy, wr_cnt - base);
        end
    endtask

    task automatic test_start_busy();
        int base;
        base = wr_cnt;
        do_start(8'd3);
        send_word(32'hA0A1_A2A3, 32'h000, 0);
        start     = 1'b1;
        num_words = 8'd1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL busy_start: busy=%b done=%b, expected 1/0", busy, done);
        end
        send_word(32'hB0B1_B2B3, 32'h004, 0);
        send_word(32'hC0C1_C2C3, 32'h008, 0);
        finish_load();
        wait_done();
        n_cmp++;
        if (wr_cnt - base != 3 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL busy_count: writes=%0d pending=%0d, expected 3/0",
                     wr_cnt - base, exp_q.size());
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        do_start(8'd1);
        send_word(32'h0102_0304, 32'h000, 0);
        n_cmp++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL chk_state: in_ready=%b busy=%b, expected 1/1", bus.in_ready, busy);
        end
        send_byte(8'hF6);
        n_cmp++;
        if (done !== 1'b1 || error !== 1'b0) begin
            n_err++;
            $display("FAIL chk_good: done=%b error=%b, expected 1/0", done, error);
        end
        do_start(8'd1);
        send_word(32'h0102_0304, 32'h000, 0);
        send_byte(8'h00);
        n_cmp++;
        if (done !== 1'b1 || error !== 1'b1) begin
            n_err++;
            $display("FAIL chk_bad: done=%b error=%b, expected 1/1", done, error);
        end
        do_start(8'd1);
        n_cmp++;
        if (error !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL chk_clear: error=%b done=%b, expected 0/0", error, done);
        end
        send_word(32'h0000_0000, 32'h000, 0);
        finish_load();
        wait_done();
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_gaps();
        test_clamp();
        test_reset_mid();
        test_start_busy();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 128, meaning instruction-memory depth in 32-bit words.
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of num_words, which must be able to hold DEPTH.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset; it is asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, meaning a one-cycle request to begin a load.
REQ-006 SHALL have port num_words, input, CNT_W, meaning the number of words to load; it is sampled when start is accepted.
REQ-007 SHALL have port in_valid, input, 1, meaning the byte-stream source holds valid data.
REQ-008 SHALL have port in_data, input, 8, meaning the byte-stream data.
REQ-009 SHALL have port in_ready, output, 1, meaning the loader accepts a byte this cycle.
REQ-010 SHALL have port mem_wr_en, output, 1, meaning an instruction-memory write strobe.
REQ-011 SHALL have port mem_wr_addr, output, 32, meaning the byte address, always word-aligned; it uses the same addressing as the memory read_address.
REQ-012 SHALL have port mem_wr_data, output, 32, meaning the instruction word being written.
REQ-013 SHALL have ports cpu_hold, busy, done and error, each output, 1, meaning respectively: hold the processor; load in progress; load complete (sticky); checksum mismatch (sticky).

Function
REQ-014 SHALL implement FSM states IDLE, RECV, WRITE and DONE, plus CHECK when REQ-030 is enabled.
REQ-015 SHALL respond to start in IDLE or DONE as follows: latch N = min(num_words, DEPTH), clear the word index, byte count, done and error, and go to RECV.
REQ-016 SHALL, when start arrives with num_words == 0, go straight to DONE next cycle with no writes.
REQ-017 SHALL ignore start while in RECV, WRITE or CHECK.
REQ-018 SHALL drive in_ready = 1 only in RECV; a byte is accepted on a cycle where in_valid && in_ready.
REQ-019 SHALL assemble each word big-endian: the first accepted byte goes to [31:24] and the fourth to [7:0].
REQ-020 SHALL move to WRITE on the cycle after the 4th byte of a word is accepted.
REQ-021 SHALL, in WRITE, assert mem_wr_en for exactly one cycle with mem_wr_addr = word_idx*4 and mem_wr_data = the assembled word.
REQ-022 SHALL, after WRITE, go to RECV if word_idx < N-1, otherwise to DONE (or CHECK).
REQ-023 SHALL make the latency from the 4th byte accepted to mem_wr_en exactly 1 cycle, giving a peak throughput of 1 word per 5 cycles.
REQ-024 SHALL hold state during in_valid gaps, with no timeout.
REQ-025 SHALL ensure word_idx never exceeds DEPTH-1, so mem_wr_addr never exceeds (DEPTH-1)*4 (0x1FC at default DEPTH).
REQ-026 SHALL drive busy = 1 in RECV, WRITE and CHECK, and drive cpu_hold = busy.
REQ-027 SHALL hold done = 1 in DONE until the next accepted start.

Reset
REQ-028 SHALL, while rst_n = 0, force state = IDLE and in_ready, mem_wr_en, busy, cpu_hold, done and error = 0, and mem_wr_addr and mem_wr_data = 0.
REQ-029 SHALL, when rst_n is asserted mid-load, discard any partial word, issue no further writes, and leave already-written words untouched.

Configuration
REQ-030 SHALL, with macro IMEM_LOADER_CHECKSUM_EN defined, enter CHECK after the last WRITE and accept one extra byte there, with in_ready = 1 in CHECK.
REQ-031 SHALL, with macro IMEM_LOADER_CHECKSUM_EN defined, set error = 1 if the mod-256 sum of all data bytes plus the checksum byte != 0, then go to DONE; done asserts regardless of error.
REQ-032 SHALL, without IMEM_LOADER_CHECKSUM_EN, omit the CHECK state and checksum logic and tie error to 0.

Structure
REQ-033 SHALL place the state enum, the WORD_BYTES = 4 constant and the default DEPTH in package imem_loader_pkg.
REQ-034 SHALL implement the shift register and 2-bit byte counter in one sub-module, imem_byte_packer, which outputs word and word_valid.

Verification
REQ-035 SHALL cover a reset-then-load test: start with num_words = 2, then bytes 20 08 00 05 8C 09 00 00 -> writes 0x20080005 @0x000, then 0x8C090000 @0x004, then done = 1 and cpu_hold = 0.
REQ-036 SHALL cover a backpressure/gap test: in_valid toggling every other cycle, one word 0xDEADBEEF -> exactly one mem_wr_en, with data 0xDEADBEEF @0x000.
REQ-037 SHALL cover a clamp test: num_words = 200 at DEPTH = 128 -> 128 writes, last at 0x1FC, then done.
REQ-038 SHALL cover reset-mid-load: rst_n low after 2 bytes of word 3 -> no write at 0x008, all outputs 0; after release, state is IDLE.
REQ-039 SHALL cover start while busy: start pulsed during RECV -> no restart, and the write address sequence stays unchanged.
REQ-040 SHALL cover the checksum (macro defined): word 01 02 03 04 with checksum byte 0xF6 -> error = 0; with checksum byte 0x00 -> error = 1 and done = 1.
